// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_wr_addr;
   logic [31:0]       imem_wr_data;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed byte stream (LEN, N LE words, XOR CHK) into instruction memory, holding the core meanwhile.
// Write strobe lands one cycle after a word's 4th byte; rx_ready depends on state only, one byte per cycle.
module imem_loader #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH_WORDS = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_req,
   imem_loader_if.master bus,
   output logic          core_hold,
   output logic          done,
   output logic          error
);

   localparam int         CNT_W   = $clog2(DEPTH_WORDS) + 1;
   localparam logic [7:0] DEPTH_B = 8'(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]        state_q,    state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]  len_q,      len_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [7:0]        xor_q,      xor_d;
   logic [23:0]       asm_q,      asm_d;
   logic              wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [31:0]       wr_data_q,  wr_data_d;

   logic             rx_ready;
   logic             accept;
   logic [CNT_W-1:0] word_inc;

   assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
   assign accept   = bus.rx_valid && rx_ready;
   assign word_inc = word_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      xor_d      = xor_q;
      asm_d      = asm_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_req) begin
               state_d    = S_LEN;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               xor_d      = '0;
            end
         end

         S_LEN: begin
            if (accept) begin
               if ((bus.rx_data == 8'd0) || (bus.rx_data > DEPTH_B)) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = CNT_W'(bus.rx_data);
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               xor_d      = xor_q ^ bus.rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: asm_d[7:0]   = bus.rx_data;
                  2'd1: asm_d[15:8]  = bus.rx_data;
                  2'd2: asm_d[23:16] = bus.rx_data;
                  default: begin
                     // Top byte goes straight into the write register; no need to store it.
                     wr_en_d    = 1'b1;
                     wr_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
                     wr_data_d  = {bus.rx_data, asm_q};
                     word_cnt_d = word_inc;
                     if (word_inc == len_q) begin
                        state_d = S_CHK;
                     end
                  end
               endcase
            end
         end

         S_CHK: begin
            if (accept) begin
               state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERR;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         word_cnt_q <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         xor_q      <= '0;
         asm_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         xor_q      <= xor_d;
         asm_q      <= asm_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign bus.rx_ready     = rx_ready;
   assign bus.imem_wr_en   = wr_en_q;
   assign bus.imem_wr_addr = wr_addr_q;
   assign bus.imem_wr_data = wr_data_q;

   assign core_hold = (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames drive the loader; expected writes are queued and checked by a separate write monitor.
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic load_req;
   logic core_hold;
   logic done;
   logic error;

   imem_loader_if #(.ADDR_W(8)) ifc ();

   imem_loader #(
      .ADDR_W      (8),
      .DEPTH_WORDS (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_req  (load_req),
      .bus       (ifc),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   int          checks = 0;
   int          errors = 0;
   logic [39:0] exp_q[$];
   logic [7:0]  frame[$];
   int          max_gap = 0;
   logic        prev_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (ifc.imem_wr_en === 1'b1) begin
         chk("wr_en_single_cycle", {31'd0, prev_we}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     ifc.imem_wr_addr, ifc.imem_wr_data);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", {24'd0, ifc.imem_wr_addr}, {24'd0, e[39:32]});
            chk("wr_data", ifc.imem_wr_data, e[31:0]);
         end
      end
      prev_we = (ifc.imem_wr_en === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      n = 0;
      while (ifc.rx_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (ifc.rx_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout: rx_ready=%b, expected 1 within 16 cycles", ifc.rx_ready);
      end
      @(negedge clk);
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'h00;
   endtask

   task automatic send_frame();
      foreach (frame[i]) begin
         send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      end
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_rx_ready"},  {31'd0, ifc.rx_ready},   32'd0);
      chk({tag, "_wr_en"},     {31'd0, ifc.imem_wr_en}, 32'd0);
      chk({tag, "_wr_addr"},   {24'd0, ifc.imem_wr_addr}, 32'd0);
      chk({tag, "_wr_data"},   ifc.imem_wr_data,        32'd0);
      chk({tag, "_core_hold"}, {31'd0, core_hold},      32'd1);
      chk({tag, "_done"},      {31'd0, done},           32'd0);
      chk({tag, "_error"},     {31'd0, error},          32'd0);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic h);
      chk({tag, "_done"},      {31'd0, done},      {31'd0, d});
      chk({tag, "_error"},     {31'd0, error},     {31'd0, e});
      chk({tag, "_core_hold"}, {31'd0, core_hold}, {31'd0, h});
      chk({tag, "_rx_ready"},  {31'd0, ifc.rx_ready}, 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic two_word_frame(input logic [7:0] chk_byte);
      exp_q.push_back({8'h00, 32'h0050_0093});
      exp_q.push_back({8'h04, 32'h00A0_0113});
      frame = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, chk_byte};
      send_frame();
   endtask

   initial begin
      reset        = 1'b1;
      load_req     = 1'b0;
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outs("reset");
      reset = 1'b0;
      @(negedge clk);

      // Clean two-word load
      pulse_load();
      chk("t1_hold_in_len", {31'd0, core_hold}, 32'd1);
      chk("t1_ready_in_len", {31'd0, ifc.rx_ready}, 32'd1);
      two_word_frame(8'h71);
      check_status("t1", 1'b1, 1'b0, 1'b0);

      // Bad checksum, words still written
      pulse_load();
      two_word_frame(8'h70);
      check_status("badchk", 1'b0, 1'b1, 1'b1);

      // Length 0 and 65 rejected without writes
      pulse_load();
      frame = '{8'h00};
      send_frame();
      check_status("len0", 1'b0, 1'b1, 1'b1);

      pulse_load();
      frame = '{8'h41};
      send_frame();
      check_status("len65", 1'b0, 1'b1, 1'b1);

      // Random gaps between bytes
      max_gap = 5;
      pulse_load();
      two_word_frame(8'h71);
      check_status("gaps", 1'b1, 1'b0, 1'b0);
      max_gap = 0;

      // Reset after six payload bytes: only the first word lands
      pulse_load();
      exp_q.push_back({8'h00, 32'h0050_0093});
      frame = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
      send_frame();
      reset = 1'b1;
      @(negedge clk);
      check_reset_outs("midreset");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("midreset_writes_left", exp_q.size(), 32'd0);

      pulse_load();
      two_word_frame(8'h71);
      check_status("after_reset", 1'b1, 1'b0, 1'b0);

      // Reload from DONE with a one-word frame
      pulse_load();
      chk("reload_hold", {31'd0, core_hold}, 32'd1);
      chk("reload_done", {31'd0, done},      32'd0);
      exp_q.push_back({8'h00, 32'hDEAD_BEEF});
      frame = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      send_frame();
      check_status("reload", 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
